// File: rtl/led_mode_sched.sv
// Six-LED display scheduler: step-rate divider, default right-flow pattern and
// fixed-priority, preemptive hold arbitration among BLINK / FLOW_L / PINGPONG requests.
module led_mode_sched #(
    parameter int unsigned TICK_DIV   = 25_000_000,
    parameter int unsigned HOLD_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] req,
    output logic [5:0] led,
    output logic [1:0] grant_id,
    output logic       busy
);

    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {
        ST_DEFAULT,
        ST_HOLD
    } state_t;

    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_pend;
    logic [1:0]       r_grant_id, w_gid_nx;
    logic [7:0]       r_hold, w_hold_nx;
    logic [5:0]       r_pat, w_pat_nx;
    logic             r_dir, w_dir_nx;      // PINGPONG direction, 1 = moving right
    logic [5:0]       r_led;

    logic             w_tick;
    logic             w_win_valid;
    logic [1:0]       w_win_idx;
    logic             w_grant;
    logic [2:0]       w_gbit;

    assign w_tick      = en && (r_cnt == CNT_W'(TICK_DIV - 1));
    assign w_win_valid = |r_pend;

    always_comb begin
        w_win_idx = 2'd2;
        if (r_pend[0])      w_win_idx = 2'd0;
        else if (r_pend[1]) w_win_idx = 2'd1;
    end

    // In HOLD the active index is grant_id-1, so "winner <= active" is "winner < grant_id".
    assign w_grant = w_win_valid && ((r_state == ST_DEFAULT) || (w_win_idx < r_grant_id));

    always_comb begin
        w_state_nx = r_state;
        w_gid_nx   = r_grant_id;
        w_hold_nx  = r_hold;
        w_pat_nx   = r_pat;
        w_dir_nx   = r_dir;
        w_gbit     = '0;
        if (w_grant) begin
            w_gbit     = 3'b001 << w_win_idx;
            w_state_nx = ST_HOLD;
            w_gid_nx   = w_win_idx + 2'd1;
            w_hold_nx  = 8'(HOLD_TICKS);
            case (w_win_idx)
                2'd0:    w_pat_nx = '1;
                2'd1:    w_pat_nx = 6'b000001;
                default: begin
                    w_pat_nx = 6'b100000;
                    w_dir_nx = 1'b1;
                end
            endcase
        end else if (w_tick) begin
            if ((r_state == ST_HOLD) && (r_hold == 8'd1)) begin
                w_state_nx = ST_DEFAULT;
                w_gid_nx   = 2'd0;
                w_pat_nx   = 6'b100000;
            end else begin
                if (r_state == ST_HOLD)
                    w_hold_nx = r_hold - 8'd1;
                case (r_grant_id)
                    2'd1:    w_pat_nx = ~r_pat;
                    2'd2:    w_pat_nx = {r_pat[4:0], r_pat[5]};
                    2'd3: begin
                        if (r_dir) begin
                            if (r_pat[0]) begin
                                w_pat_nx = 6'b000010;
                                w_dir_nx = 1'b0;
                            end else begin
                                w_pat_nx = r_pat >> 1;
                            end
                        end else begin
                            if (r_pat[5]) begin
                                w_pat_nx = 6'b010000;
                                w_dir_nx = 1'b1;
                            end else begin
                                w_pat_nx = r_pat << 1;
                            end
                        end
                    end
                    default: w_pat_nx = {r_pat[0], r_pat[5:1]};
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_DEFAULT;
            r_cnt      <= '0;
            r_pend     <= '0;
            r_grant_id <= '0;
            r_hold     <= '0;
            r_pat      <= 6'b100000;
            r_dir      <= 1'b1;
            r_led      <= '0;
        end else begin
            if (!en || w_tick)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            r_pend     <= (r_pend & ~w_gbit) | req;
            r_state    <= w_state_nx;
            r_grant_id <= w_gid_nx;
            r_hold     <= w_hold_nx;
            r_pat      <= w_pat_nx;
            r_dir      <= w_dir_nx;
            r_led      <= en ? r_pat : '0;
        end
    end

    assign led      = r_led;
    assign grant_id = r_grant_id;
    assign busy     = (r_state == ST_HOLD);

endmodule

// File: tb/tb_led_mode_sched.sv
// Directed bench for led_mode_sched: per-segment vector table on a short-hold
// instance, plus a long-hold instance walking the full PINGPONG bounce.
module tb_led_mode_sched;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [2:0] req;
    logic [5:0] led;
    logic [1:0] grant_id;
    logic       busy;

    logic       rst2, en2;
    logic [2:0] req2;
    logic [5:0] led2;
    logic [1:0] grant_id2;
    logic       busy2;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    led_mode_sched #(.TICK_DIV(4), .HOLD_TICKS(3)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .led(led), .grant_id(grant_id), .busy(busy)
    );

    led_mode_sched #(.TICK_DIV(2), .HOLD_TICKS(12)) dut2 (
        .clk(clk), .rst(rst2), .en(en2), .req(req2),
        .led(led2), .grant_id(grant_id2), .busy(busy2)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic [2:0]  req;
        int unsigned n;       // cycles to hold these inputs before checking
        logic [5:0]  led;
        logic [1:0]  gid;
        logic        busy;
    } vec_t;

    vec_t tv[$];

    task automatic v(input logic r, input logic e, input logic [2:0] q, input int unsigned n,
                     input logic [5:0] l, input logic [1:0] g, input logic b);
        vec_t x;
        x.rst = r; x.en = e; x.req = q; x.n = n; x.led = l; x.gid = g; x.busy = b;
        tv.push_back(x);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0b want=%0b", name, idx, got, exp);
        end
    endtask

    logic [5:0] pp_seq [11];

    initial begin
        rst = 1'b1; en = 1'b0; req = '0;
        rst2 = 1'b1; en2 = 1'b0; req2 = '0;

        // reset, default FLOW_R
        v(1,0,3'b000,2, 6'b000000,0,0);
        v(0,1,3'b000,1, 6'b100000,0,0);
        v(0,1,3'b000,3, 6'b100000,0,0);
        v(0,1,3'b000,1, 6'b010000,0,0);
        v(0,1,3'b000,4, 6'b001000,0,0);
        v(0,1,3'b000,4, 6'b000100,0,0);
        v(0,1,3'b000,4, 6'b000010,0,0);
        v(0,1,3'b000,4, 6'b000001,0,0);
        v(0,1,3'b000,4, 6'b100000,0,0);
        // FLOW_L hold and expiry
        v(0,1,3'b010,1, 6'b100000,0,0);
        v(0,1,3'b000,1, 6'b100000,2,1);
        v(0,1,3'b000,1, 6'b000001,2,1);
        v(0,1,3'b000,1, 6'b000010,2,1);
        v(0,1,3'b000,4, 6'b000100,2,1);
        v(0,1,3'b000,3, 6'b000100,0,0);
        v(0,1,3'b000,1, 6'b100000,0,0);
        // PINGPONG preempted by BLINK, hold restarts
        v(0,1,3'b100,1, 6'b100000,0,0);
        v(0,1,3'b000,1, 6'b100000,3,1);
        v(0,1,3'b000,2, 6'b010000,3,1);
        v(0,1,3'b000,3, 6'b010000,3,1);
        v(0,1,3'b001,1, 6'b001000,3,1);
        v(0,1,3'b000,1, 6'b001000,1,1);
        v(0,1,3'b000,1, 6'b111111,1,1);
        v(0,1,3'b000,2, 6'b000000,1,1);
        v(0,1,3'b000,4, 6'b111111,1,1);
        v(0,1,3'b000,3, 6'b111111,0,0);
        v(0,1,3'b000,1, 6'b100000,0,0);
        // simultaneous BLINK + PINGPONG
        v(0,1,3'b101,1, 6'b100000,0,0);
        v(0,1,3'b000,1, 6'b100000,1,1);
        v(0,1,3'b000,1, 6'b111111,1,1);
        v(0,1,3'b000,4, 6'b000000,1,1);
        v(0,1,3'b000,4, 6'b111111,0,0);
        v(0,1,3'b000,1, 6'b100000,3,1);
        // en low freezes the hold
        v(0,1,3'b000,3, 6'b100000,3,1);
        v(0,0,3'b000,1, 6'b000000,3,1);
        v(0,0,3'b000,19,6'b000000,3,1);
        v(0,1,3'b000,1, 6'b010000,3,1);
        v(0,1,3'b000,3, 6'b010000,3,1);
        v(0,1,3'b000,1, 6'b001000,3,1);
        v(0,1,3'b000,3, 6'b001000,0,0);
        v(0,1,3'b000,1, 6'b100000,0,0);
        // reset mid-hold drops the pending PINGPONG
        v(0,1,3'b010,1, 6'b100000,0,0);
        v(0,1,3'b000,1, 6'b100000,2,1);
        v(0,1,3'b100,1, 6'b000001,2,1);
        v(0,1,3'b000,1, 6'b000010,2,1);
        v(1,1,3'b000,1, 6'b000000,0,0);
        v(0,1,3'b000,1, 6'b100000,0,0);
        v(0,1,3'b000,7, 6'b010000,0,0);
        // grant while blanked, then a full period before the first step
        v(0,0,3'b001,1, 6'b000000,0,0);
        v(0,0,3'b000,1, 6'b000000,1,1);
        v(0,1,3'b000,1, 6'b111111,1,1);
        v(0,1,3'b000,3, 6'b111111,1,1);
        v(0,1,3'b000,1, 6'b000000,1,1);

        foreach (tv[i]) begin
            rst = tv[i].rst; en = tv[i].en; req = tv[i].req;
            @(posedge clk); #1;
            req = '0;
            for (int unsigned c = 1; c < tv[i].n; c++) begin
                @(posedge clk); #1;
            end
            chk("led",  i, 32'(led),      32'(tv[i].led));
            chk("gid",  i, 32'(grant_id), 32'(tv[i].gid));
            chk("busy", i, 32'(busy),     32'(tv[i].busy));
        end

        // full PINGPONG bounce on the long-hold instance
        pp_seq = '{6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001, 6'b000010,
                   6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b010000};
        rst2 = 1'b0; en2 = 1'b1; req2 = 3'b100;
        @(posedge clk); #1;
        req2 = '0;
        chk("pp_pend_gid", 0, 32'(grant_id2), 32'd0);
        @(posedge clk); #1;
        chk("pp_grant_gid", 0, 32'(grant_id2), 32'd3);
        chk("pp_grant_busy", 0, 32'(busy2), 32'd1);
        @(posedge clk); #1;
        chk("pp_start", 0, 32'(led2), 32'b100000);
        for (int i = 0; i < 11; i++) begin
            repeat (2) @(posedge clk);
            #1;
            chk("pp_step", i, 32'(led2), 32'(pp_seq[i]));
        end
        @(posedge clk); #1;
        chk("pp_end_gid", 0, 32'(grant_id2), 32'd0);
        chk("pp_end_busy", 0, 32'(busy2), 32'd0);
        @(posedge clk); #1;
        chk("pp_end_led", 0, 32'(led2), 32'b100000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_mode_sched.md
Name: led_mode_sched

Overview:
- Scheduler for the 6-LED display. Owns the step-rate divider and the current display pattern.
- Default pattern is a right-shifting single-LED flow.
- Three requesters (alarm, event, idle-show) can each claim the LEDs for a fixed number of steps, arbitrated by fixed priority with preemption.
- Sits between game/control logic and the board LED pins.

Parameters:
- TICK_DIV, 25_000_000: clk cycles per pattern step; must be ≥ 2.
- HOLD_TICKS, 8: pattern steps a granted request owns the LEDs; must be 1..255.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- en  input  1  display enable; 0 blanks the LEDs
- req  input  3  request pulses; bit0 = BLINK (highest priority), bit1 = FLOW_L, bit2 = PINGPONG (lowest)
- led  output  6  registered LED drive; bit5 = leftmost
- grant_id  output  2  0 = default FLOW_R, 1/2/3 = req bit 0/1/2 active
- busy  output  1  1 while a request owns the LEDs (grant_id != 0)

Behaviour:
- Reset, sampled at posedge clk:
  - led = 000000, grant_id = 0, busy = 0.
  - Pattern register = 100000, pending = 000, tick counter = 0, hold counter = 0, state = DEFAULT.
- Tick:
  - Counter runs 0..TICK_DIV-1 while en = 1. Internal tick is high for one cycle when count == TICK_DIV-1, then the counter wraps to 0.
  - en = 0 clears the counter and suppresses ticks.
- Pending: each cycle, pending <= (pending & ~granted_bit) | req. A req pulse arriving in the same cycle its bit is granted stays pending.
- States: DEFAULT and HOLD. grant_id and busy are registered and update with the state.
- Arbitration happens every cycle, regardless of tick.
  - Winner = lowest-index set pending bit.
  - DEFAULT: any pending → grant the winner, go to HOLD.
  - HOLD: grant if winner index ≤ active index. This covers preemption by higher priority and restart by the same requester. Lower-priority bits stay pending.
- Grant actions:
  - Load the mode start pattern and set hold = HOLD_TICKS.
  - Clear the winner's pending bit and set grant_id = winner+1.
  - A grant in the same cycle as a tick takes precedence: load the start pattern, no step.
- Pattern step on each tick (when no grant that cycle):
  - FLOW_R (default): start 100000, shift right; 000001 → 100000.
  - FLOW_L: start 000001, shift left; 100000 → 000001.
  - BLINK: start 111111; toggles 111111 ↔ 000000.
  - PINGPONG: start 100000, direction right.
    - Direction reverses at the ends, and each end is shown once.
    - Sequence: 100000, 010000, …, 000001, 000010, …, 100000, 010000, …
- Hold countdown in HOLD:
  - Each tick decrements hold.
  - On the tick where hold goes 1 → 0: return to DEFAULT, load pattern 100000, grant_id = 0.
  - If a bit is pending in that cycle, it is granted on the next cycle.
- Output:
  - led <= en ? pattern : 000000, registered. led lags the pattern register by one cycle.
  - Latency from a req pulse at edge N to the new start pattern on led: edge N+2 (pending at N+1, grant/pattern at N+2 … led visible after edge N+2 with en = 1).
- en = 0:
  - State, pattern and hold are frozen because there are no ticks.
  - Requests are still latched and arbitrated; a grant still loads its start pattern and sets hold.
  - Reasserting en resumes from the frozen point with a full TICK_DIV period before the first step.
- Reset mid-HOLD: everything returns to reset values on the next edge, and pending requests are discarded.

Test Plan (TICK_DIV = 4, HOLD_TICKS = 3):
- Reset then en = 1, no req → led 000000 until the first pattern load. It then steps 100000, 010000, …, 000001, 100000 every 4 cycles; grant_id = 0.
- req = 010 pulse → grant_id = 2 two edges later and led = 000001. It steps 000010, 000100. On the 3rd tick it returns to 100000 with grant_id = 0 and busy = 0.
- req = 100 then req = 001 two ticks later → PINGPONG preempted, grant_id = 1, led = 111111, 000000, 111111. Hold restarts at 3, and grant_id returns to 0 after 3 ticks.
- req = 001 and req = 100 in the same cycle → BLINK granted first. After the BLINK hold expires, PINGPONG is granted the next cycle with led = 100000 and grant_id = 3.
- en = 0 during HOLD for 20 cycles → led = 000000 and hold is frozen. After en returns to 1, the remaining ticks complete the hold.
- rst pulsed mid-HOLD with req = 100 also pending → led = 000000, grant_id = 0, pending cleared. No grant follows without a new req.
